reshaper_job_ctrl: RTL



---
 rtl/reshaper_job_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reshaper_job_ctrl.sv
// -----------------------------------------------------------------------------
// reshaper_job_ctrl
//
// Job sequencer for the reshaper datapath. Reshape descriptors arrive over a
// valid/ready port and are buffered in a small FIFO. Jobs run one at a time:
// the descriptor is registered onto the reshaper configuration outputs, an init
// pulse is issued, the sequencer waits for finish and then reports completion
// with the job ID and an error flag. A programmable watchdog aborts hung jobs.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   job_vld / job_rdy      descriptor handshake (job_rdy = queue not full)
//   job_id, job_*          descriptor tag, scalars and per-dimension arrays
//   tmo_cycles             watchdog limit in RUN cycles (0 = disabled)
//   rs_*                   registered reshaper configuration
//   rs_init_pulse          one-cycle reshaper init
//   rs_finish              reshaper finish
//   done_vld/id/err        one-cycle completion strobe, job ID, abort flag
//   busy                   job in flight or queue non-empty
// -----------------------------------------------------------------------------
module reshaper_job_ctrl #(
  parameter int AW   = 16,
  parameter int ADIM = 6,
  parameter int IDW  = 4,
  parameter int QD   = 2,
  parameter int TW   = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     job_vld,
  output logic                     job_rdy,
  input  logic [IDW-1:0]           job_id,
  input  logic [AW-1:0]            job_rreq_num,
  input  logic [AW-1:0]            job_raddr_base,
  input  logic [AW-1:0]            job_wreq_num,
  input  logic [AW-1:0]            job_waddr_base,
  input  logic [AW-1:0]            job_rdata_size,
  input  logic [AW-1:0]            job_wdata_size,
  input  logic [ADIM-1:0][AW-1:0]  job_raddr_size,
  input  logic [ADIM-1:0][AW-1:0]  job_raddr_stride,
  input  logic [ADIM-1:0][AW-1:0]  job_waddr_size,
  input  logic [ADIM-1:0][AW-1:0]  job_waddr_stride,
  input  logic [TW-1:0]            tmo_cycles,
  output logic [AW-1:0]            rs_rreq_num,
  output logic [AW-1:0]            rs_raddr_base,
  output logic [AW-1:0]            rs_wreq_num,
  output logic [AW-1:0]            rs_waddr_base,
  output logic [AW-1:0]            rs_rdata_size,
  output logic [AW-1:0]            rs_wdata_size,
  output logic [ADIM-1:0][AW-1:0]  rs_raddr_size,
  output logic [ADIM-1:0][AW-1:0]  rs_raddr_stride,
  output logic [ADIM-1:0][AW-1:0]  rs_waddr_size,
  output logic [ADIM-1:0][AW-1:0]  rs_waddr_stride,
  output logic                     rs_init_pulse,
  input  logic                     rs_finish,
  output logic                     done_vld,
  output logic [IDW-1:0]           done_id,
  output logic                     done_err,
  output logic                     busy
);

  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDW-1:0]          id;
    logic [AW-1:0]           rreq_num;
    logic [AW-1:0]           raddr_base;
    logic [AW-1:0]           wreq_num;
    logic [AW-1:0]           waddr_base;
    logic [AW-1:0]           rdata_size;
    logic [AW-1:0]           wdata_size;
    logic [ADIM-1:0][AW-1:0] raddr_size;
    logic [ADIM-1:0][AW-1:0] raddr_stride;
    logic [ADIM-1:0][AW-1:0] waddr_size;
    logic [ADIM-1:0][AW-1:0] waddr_stride;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    GUARD = 3'd3,
    RUN   = 3'd4,
    ABORT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             phase_r;        // second cycle of GUARD / ABORT

  desc_t            q_mem_r [QD];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             push_s;
  logic             pop_s;
  desc_t            in_desc_s;
  desc_t            head_s;
  logic             head_zero_s;

  desc_t            cfg_r;          // live reshaper config; id = job in flight
  logic [TW-1:0]    tmo_r;
  logic [TW-1:0]    wd_r;
  logic             timeout_s;

  logic             job_rdy_r;
  logic             busy_r;
  logic             init_pulse_r;
  logic             done_vld_r;
  logic [IDW-1:0]   done_id_r;
  logic             done_err_r;

  // Gather the descriptor port into one record for queue storage
  always_comb begin
    in_desc_s              = '0;
    in_desc_s.id           = job_id;
    in_desc_s.rreq_num     = job_rreq_num;
    in_desc_s.raddr_base   = job_raddr_base;
    in_desc_s.wreq_num     = job_wreq_num;
    in_desc_s.waddr_base   = job_waddr_base;
    in_desc_s.rdata_size   = job_rdata_size;
    in_desc_s.wdata_size   = job_wdata_size;
    in_desc_s.raddr_size   = job_raddr_size;
    in_desc_s.raddr_stride = job_raddr_stride;
    in_desc_s.waddr_size   = job_waddr_size;
    in_desc_s.waddr_stride = job_waddr_stride;
  end

  assign head_s      = q_mem_r[rd_ptr_r];
  assign head_zero_s = (head_s.rreq_num == {AW{1'b0}}) && (head_s.wreq_num == {AW{1'b0}});

  // Queue handshake and occupancy update; job_rdy comes from a register so
  // job_vld never reaches it combinationally
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    count_next_s = count_r;
    if (job_vld && job_rdy_r) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (state_r == LOAD) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Watchdog hits its limit when the next increment would reach tmo_r;
  // the extra bit keeps a saturated counter from matching by wrap-around
  assign timeout_s = (tmo_r != {TW{1'b0}}) &&
                     (({1'b0, wd_r} + {{TW{1'b0}}, 1'b1}) == {1'b0, tmo_r});

  // Next-state logic of the job sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if ((count_r != {CW{1'b0}}) || push_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        // a job with nothing to read or write completes without an init
        if (head_zero_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = INIT;
        end
      end
      INIT: begin
        state_next_s = GUARD;
      end
      GUARD: begin
        // finish is ignored here: it may still reflect the previous job
        if (phase_r) begin
          state_next_s = RUN;
        end else begin
          state_next_s = GUARD;
        end
      end
      RUN: begin
        // finish has priority over a timeout in the same cycle
        if (rs_finish) begin
          state_next_s = DONE;
        end else if (timeout_s) begin
          state_next_s = ABORT;
        end else begin
          state_next_s = RUN;
        end
      end
      ABORT: begin
        if (phase_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ABORT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus the two-cycle phase bit used by GUARD and ABORT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      phase_r <= ((state_r == GUARD) || (state_r == ABORT)) && !phase_r;
    end
  end

  // Descriptor FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QD; i++) begin
        q_mem_r[i] <= '0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        q_mem_r[wr_ptr_r] <= in_desc_s;
        wr_ptr_r          <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
    end
  end

  // Reshaper configuration: loaded from the queue head, request counts
  // cleared on the way into ABORT so the quiesce init starts nothing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_r <= '0;
    end else if (state_r == LOAD) begin
      cfg_r <= head_s;
    end else if ((state_r == RUN) && (state_next_s == ABORT)) begin
      cfg_r.rreq_num <= {AW{1'b0}};
      cfg_r.wreq_num <= {AW{1'b0}};
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // Watchdog: limit sampled and counter cleared at INIT, counts RUN cycles,
  // saturates instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_r <= {TW{1'b0}};
      wd_r  <= {TW{1'b0}};
    end else if (state_r == INIT) begin
      tmo_r <= tmo_cycles;
      wd_r  <= {TW{1'b0}};
    end else if ((state_r == RUN) && (wd_r != {TW{1'b1}})) begin
      wd_r <= wd_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      wd_r <= wd_r;
    end
  end

  // Registered strobes and status, computed from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_rdy_r    <= 1'b1;
      busy_r       <= 1'b0;
      init_pulse_r <= 1'b0;
      done_vld_r   <= 1'b0;
      done_id_r    <= {IDW{1'b0}};
      done_err_r   <= 1'b0;
    end else begin
      job_rdy_r    <= (count_next_s != CW'(QD));
      busy_r       <= (state_next_s != IDLE) || (count_next_s != {CW{1'b0}});
      init_pulse_r <= ((state_r == LOAD) && (state_next_s == INIT)) ||
                      ((state_r == ABORT) && !phase_r);
      done_vld_r   <= (state_next_s == DONE);
      if (state_next_s == DONE) begin
        // a zero job goes LOAD -> DONE before cfg_r has captured its ID
        done_id_r  <= (state_r == LOAD) ? head_s.id : cfg_r.id;
        done_err_r <= (state_r == ABORT);
      end else begin
        done_id_r  <= {IDW{1'b0}};
        done_err_r <= 1'b0;
      end
    end
  end

  assign job_rdy          = job_rdy_r;
  assign busy             = busy_r;
  assign rs_init_pulse    = init_pulse_r;
  assign done_vld         = done_vld_r;
  assign done_id          = done_id_r;
  assign done_err         = done_err_r;
  assign rs_rreq_num      = cfg_r.rreq_num;
  assign rs_raddr_base    = cfg_r.raddr_base;
  assign rs_wreq_num      = cfg_r.wreq_num;
  assign rs_waddr_base    = cfg_r.waddr_base;
  assign rs_rdata_size    = cfg_r.rdata_size;
  assign rs_wdata_size    = cfg_r.wdata_size;
  assign rs_raddr_size    = cfg_r.raddr_size;
  assign rs_raddr_stride  = cfg_r.raddr_stride;
  assign rs_waddr_size    = cfg_r.waddr_size;
  assign rs_waddr_stride  = cfg_r.waddr_stride;

endmodule
